// File: rtl/booth_radix4_seq_if.sv
// Start/busy/done handshake bundle for the radix-4 Booth multiplier.
// The master drives operands and start; the slave returns status and product.
interface booth_radix4_seq_if #(
  parameter int N = 32
);
  logic           start;
  logic           is_signed;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start,
    output is_signed,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  is_signed,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/booth_radix4_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed/unsigned.
// Optional macro BOOTH_EARLY_TERM_EN ends RUN once all remaining digits are 0.
module booth_radix4_seq #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                reset,
  booth_radix4_seq_if.slave   bus
);
  localparam int ITER = N / 2 + 1;
  localparam int EW   = N + 2;
  localparam int AW   = 2 * N + 4;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((N % 2) != 0 || N < 4) begin : g_bad_n
      $error("booth_radix4_seq: N must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [AW-1:0]  r_acc;
  logic [AW-1:0]  r_mcand;
  logic [EW-1:0]  r_mplr;
  logic           r_g;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;

  logic           w_load;
  logic [EW-1:0]  w_a_ext;
  logic [EW-1:0]  w_b_ext;
  logic [AW-1:0]  w_mc2;
  logic [AW-1:0]  w_addend;
  logic [AW-1:0]  w_acc_nx;
  logic [EW-1:0]  w_mplr_nx;
  logic           w_g_nx;
  logic           w_last;
  logic           w_fin;

  assign w_load  = bus.start && (r_state != S_RUN);
  assign w_a_ext = {{2{bus.is_signed & bus.multiplicand[N-1]}},
                    bus.multiplicand};
  assign w_b_ext = {{2{bus.is_signed & bus.multiplier[N-1]}},
                    bus.multiplier};

  assign w_mc2 = {r_mcand[AW-2:0], 1'b0};

  always_comb begin
    w_addend = '0;
    case ({r_mplr[1:0], r_g})
      3'b001,
      3'b010:  w_addend = r_mcand;
      3'b011:  w_addend = w_mc2;
      3'b100:  w_addend = -w_mc2;
      3'b101,
      3'b110:  w_addend = -r_mcand;
      default: w_addend = '0;
    endcase
  end

  assign w_acc_nx  = r_acc + w_addend;
  assign w_mplr_nx = {{2{r_mplr[EW-1]}}, r_mplr[EW-1:2]};
  assign w_g_nx    = r_mplr[1];
  assign w_last    = (r_cnt == CW'(ITER - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // Remaining bits all equal to the guard means every later digit is 0.
  assign w_fin = w_last || (w_mplr_nx == {EW{w_g_nx}});
`else
  assign w_fin = w_last;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (bus.start) w_state_nx = S_RUN;
      end
      (r_state == S_RUN): begin
        if (w_fin) w_state_nx = S_DONE;
      end
      (r_state == S_DONE): begin
        w_state_nx = bus.start ? S_RUN : S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_g       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_acc     <= '0;
      r_mcand   <= {{(AW-EW){w_a_ext[EW-1]}}, w_a_ext};
      r_mplr    <= w_b_ext;
      r_g       <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == S_RUN) begin
      r_acc     <= w_acc_nx;
      r_mcand   <= {r_mcand[AW-3:0], 2'b00};
      r_mplr    <= w_mplr_nx;
      r_g       <= w_g_nx;
      r_cnt     <= r_cnt + CW'(1);
      if (w_fin) r_product <= w_acc_nx[2*N-1:0];
    end
  end

  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule

// File: tb/tb_booth_radix4_seq.sv
// Scoreboard bench for booth_radix4_seq at N=8: directed vectors,
// handshake corner cases, async reset, and a short model-checked loop.
module tb_booth_radix4_seq;
  localparam int N    = 8;
  localparam int ITER = N / 2 + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_radix4_seq_if #(.N(N)) bus ();

  booth_radix4_seq #(.N(N)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2*N-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got done=1 expected no pending op");
      end else begin
        chk("product", bus.product, exp_q.pop_front());
      end
    end
  end

  function automatic logic [15:0] model(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'({56'b0, a}) * longint'({56'b0, b});
    return p[15:0];
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input bit push,
                        input logic [15:0] exp);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 64) begin
      if (bus.busy === 1'b1) bcnt++;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (cyc >= 64) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no done expected done within 64");
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp,
                        output int cyc, output int bcnt);
    launch(a, b, s, 1'b1, exp);
    wait_done(cyc, bcnt);
  endtask

  initial begin
    int cyc;
    int bcnt;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rs;

    bus.start        = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    rst_n            = 1'b0;
    #12;
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    chk("rst_done", {63'b0, bus.done}, 64'd0);
    chk("rst_product", {48'b0, bus.product}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd255, 8'd255, 1'b0, 16'hFE01, cyc, bcnt);
`ifndef BOOTH_EARLY_TERM_EN
    chk("latency_255x255", cyc, ITER);
    chk("busy_cycles", bcnt, ITER);
`endif
    run_op(8'h80, 8'h80, 1'b1, 16'h4000, cyc, bcnt);
    run_op(8'hFF, 8'h01, 1'b1, 16'hFFFF, cyc, bcnt);
    run_op(8'h7F, 8'h80, 1'b1, 16'hC080, cyc, bcnt);
    run_op(8'h80, 8'h80, 1'b0, 16'h4000, cyc, bcnt);
    run_op(8'h03, 8'hF9, 1'b1, 16'hFFEB, cyc, bcnt);
    run_op(8'h00, 8'hC8, 1'b0, 16'h0000, cyc, bcnt);
    run_op(8'hAA, 8'h55, 1'b0, 16'h3872, cyc, bcnt);

    repeat (3) @(posedge clk);
    #1;
    chk("product_hold", {48'b0, bus.product}, 64'h3872);

    // start pulsed mid-RUN with other operands must be ignored
    launch(8'd10, 8'd11, 1'b0, 1'b1, 16'd110);
    @(negedge clk);
    bus.multiplicand = 8'd1;
    bus.multiplier   = 8'd1;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bcnt);
    repeat (ITER + 2) @(posedge clk);
    #1;
    chk("ignored_start_q", exp_q.size(), 0);
    chk("ignored_start_busy", {63'b0, bus.busy}, 64'd0);

    // start held through DONE launches the next op immediately
    @(negedge clk);
    bus.multiplicand = 8'd12;
    bus.multiplier   = 8'd13;
    bus.is_signed    = 1'b0;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(16'h009C);
    @(negedge clk);
    bus.multiplicand = 8'hFD;
    bus.multiplier   = 8'h05;
    bus.is_signed    = 1'b1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 64) begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_timeout: got no done expected done");
    end
    exp_q.push_back(16'hFFF1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_no_idle", {63'b0, bus.busy}, 64'd1);
    wait_done(cyc, bcnt);

    // async reset while an op is in flight
    launch(8'd200, 8'd100, 1'b0, 1'b0, 16'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst_done", {63'b0, bus.done}, 64'd0);
    chk("midrst_product", {48'b0, bus.product}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd3, 8'd7, 1'b0, 16'h0015, cyc, bcnt);

`ifdef BOOTH_EARLY_TERM_EN
    run_op(8'd9, 8'd1, 1'b0, 16'h0009, cyc, bcnt);
    chk("early_9x1_cyc", cyc, 1);
    run_op(8'd9, 8'd3, 1'b0, 16'h001B, cyc, bcnt);
    chk("early_9x3_cyc", cyc, 2);
    run_op(8'd5, 8'hFF, 1'b1, 16'hFFFB, cyc, bcnt);
    chk("early_5xm1_cyc", cyc, 1);
    run_op(8'd77, 8'd0, 1'b0, 16'h0000, cyc, bcnt);
    chk("early_zero_cyc", cyc, 1);
`else
    run_op(8'd9, 8'd1, 1'b0, 16'h0009, cyc, bcnt);
    chk("fixed_9x1_cyc", cyc, ITER);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), cyc, bcnt);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
